// File: rtl/sram_byte_reader_pkg.sv
// Shared types for the SRAM byte reader.
//   state_t    : transaction FSM states
//   byte_idx_t : index of a byte within a 32-bit word
//   rd_tag_t   : tag carried alongside each outstanding byte read
//   lane_of()  : maps a byte index to its rsp_data lane for a given byte order
package sram_ctrl_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef logic [1:0] byte_idx_t;

    typedef struct packed {
        logic      valid;
        byte_idx_t idx;
    } rd_tag_t;

    // Big-endian puts byte 0 in the top lane, so the lane is mirrored.
    function automatic byte_idx_t lane_of(input byte_idx_t idx, input logic big_endian);
        byte_idx_t top;
        top = byte_idx_t'(BYTES_PER_WORD - 1);
        return big_endian ? (top - idx) : idx;
    endfunction

endpackage

// File: rtl/sram_byte_reader_if.sv
// Bus bundle for the SRAM byte reader.
//   req_*  : word read request (valid/ready), word address, byte order select
//   sram_* : byte-wide SRAM read port (strobe, byte address, returned byte)
//   rsp_*  : assembled word response (valid/ready)
// Modport slave is used by the reader; master is used by its environment.
interface sram_byte_reader_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_big_endian;

    logic              sram_ren;
    logic [ADDR_W+1:0] sram_addr;
    logic [7:0]        sram_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;

    modport slave (
        input  req_valid, req_addr, req_big_endian, sram_rdata, rsp_ready,
        output req_ready, sram_ren, sram_addr, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_addr, req_big_endian, sram_rdata, rsp_ready,
        input  req_ready, sram_ren, sram_addr, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_rd_tag_pipe.sv
// Delay line for read tags, READ_LAT stages deep, so that each tag emerges
// in the same cycle the SRAM presents the byte it describes.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset, clears all tags
//   push : tag for the read issued this cycle (valid=0 when idle)
//   pop  : tag matching the byte currently on sram_rdata
module sram_rd_tag_pipe
    import sram_ctrl_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic    CLK,
    input  logic    nRST,
    input  rd_tag_t push,
    output rd_tag_t pop
);

    rd_tag_t tag_p [READ_LAT];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < READ_LAT; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= push;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign pop = tag_p[READ_LAT-1];

endmodule

// File: rtl/sram_byte_reader.sv
// Reads one 32-bit word from a byte-wide SRAM as four pipelined byte reads
// and assembles it in little- or big-endian order, chosen per request.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset, aborts any transaction
//   bus  : request, SRAM port and response signals (slave modport)
module sram_byte_reader
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    sram_byte_reader_if.slave   bus
);

    state_t            state;
    state_t            state_nxt;
    logic              be_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       data_q;
    rd_tag_t           push;
    rd_tag_t           pop;
    byte_idx_t         k;
    byte_idx_t         lane;
    logic              accept;
    logic              last_cap;

    // The low two bits of the registered byte address double as the issue
    // counter, which also lets sram_addr hold its last value after ISSUE.
    assign k        = addr_q[1:0];
    assign accept   = bus.req_valid && (state == IDLE);
    assign last_cap = pop.valid && (pop.idx == 2'd3);
    assign lane     = lane_of(pop.idx, be_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.req_valid)  state_nxt = ISSUE;
            ISSUE: if (k == 2'd3)      state_nxt = DRAIN;
            DRAIN: if (last_cap)       state_nxt = DONE;
            DONE:  if (bus.rsp_ready)  state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q <= '0;
            be_q   <= 1'b0;
            data_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= {bus.req_addr, 2'b00};
                be_q   <= bus.req_big_endian;
                data_q <= '0;
            end else begin
                if ((state == ISSUE) && (k != 2'd3)) begin
                    addr_q[1:0] <= k + 2'd1;
                end
                if (pop.valid) begin
                    data_q[{lane, 3'b000} +: 8] <= bus.sram_rdata;
                end
            end
        end
    end

    assign push.valid = (state == ISSUE);
    assign push.idx   = k;

    sram_rd_tag_pipe #(
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .CLK  (CLK),
        .nRST (nRST),
        .push (push),
        .pop  (pop)
    );

    assign bus.req_ready = (state == IDLE);
    assign bus.sram_ren  = (state == ISSUE);
    assign bus.sram_addr = addr_q;
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_data  = data_q;

endmodule
